// File: rtl/ip2_test3_result_fifo.sv
// ip2_test3_result_fifo: captures test3 DNN results on done rising edge and queues them with popcounts
module ip2_test3_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic        sm_test3_o_status_done,
  input  logic [47:0] sm_test3_o_dnn_output_0,
  input  logic [47:0] sm_test3_o_dnn_output_1,
  input  logic        rd_en,
  output logic        rd_valid,
  output logic [47:0] rd_data_0,
  output logic [47:0] rd_data_1,
  output logic [5:0]  rd_popcnt_0,
  output logic [5:0]  rd_popcnt_1,
  output logic [4:0]  fifo_count,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic [7:0]  overflow_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] FULL_CNT = 5'(DEPTH);

  function automatic logic [5:0] popcnt(input logic [47:0] d);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 48; i++) c = c + {5'd0, d[i]};
    return c;
  endfunction

  logic          rst;
  logic          done_q;
  logic          done_re;
  logic          cap_valid_q, cap_valid_d;
  logic [47:0]   cap_d0_q, cap_d1_q;
  logic [5:0]    pc0, pc1;
  logic          wr, rd, wr_acc, drop;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          empty_q, empty_d, full_q, full_d;
  logic [7:0]    ovf_q, ovf_d;
  logic          rd_valid_q, rd_valid_d;
  logic [47:0]   rdd0_q, rdd0_d, rdd1_q, rdd1_d;
  logic [5:0]    rdp0_q, rdp0_d, rdp1_q, rdp1_d;
  logic [47:0]   mem_d0 [DEPTH];
  logic [47:0]   mem_d1 [DEPTH];
  logic [5:0]    mem_p0 [DEPTH];
  logic [5:0]    mem_p1 [DEPTH];

  assign rst     = reset | ~enable;
  assign done_re = sm_test3_o_status_done & ~done_q;
  assign pc0     = popcnt(cap_d0_q);
  assign pc1     = popcnt(cap_d1_q);
  assign wr      = cap_valid_q & ~clear;
  assign rd      = rd_en & ~empty_q & ~clear;
  assign wr_acc  = wr & (~full_q | rd);
  assign drop    = wr & full_q & ~rd;

  // next-state for pointers, occupancy, flags, overflow counter and read registers
  always_comb begin
    cap_valid_d = done_re & ~clear;
    wptr_d      = clear ? '0 : wptr_q + AW'(wr_acc);
    rptr_d      = clear ? '0 : rptr_q + AW'(rd);
    cnt_d       = clear ? '0 : cnt_q + 5'(wr_acc) - 5'(rd);
    empty_d     = cnt_d == 5'd0;
    full_d      = cnt_d == FULL_CNT;
    ovf_d       = clear ? '0 : (drop && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
    rd_valid_d  = rd;
    rdd0_d      = rd ? mem_d0[rptr_q] : rdd0_q;
    rdd1_d      = rd ? mem_d1[rptr_q] : rdd1_q;
    rdp0_d      = rd ? mem_p0[rptr_q] : rdp0_q;
    rdp1_d      = rd ? mem_p1[rptr_q] : rdp1_q;
  end

  // control state; disable behaves exactly like reset
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q      <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_d0_q    <= '0;
      cap_d1_q    <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      ovf_q       <= '0;
      rd_valid_q  <= 1'b0;
      rdd0_q      <= '0;
      rdd1_q      <= '0;
      rdp0_q      <= '0;
      rdp1_q      <= '0;
    end else begin
      done_q      <= sm_test3_o_status_done;
      cap_valid_q <= cap_valid_d;
      if (done_re) begin
        cap_d0_q <= sm_test3_o_dnn_output_0;
        cap_d1_q <= sm_test3_o_dnn_output_1;
      end
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      rd_valid_q  <= rd_valid_d;
      rdd0_q      <= rdd0_d;
      rdd1_q      <= rdd1_d;
      rdp0_q      <= rdp0_d;
      rdp1_q      <= rdp1_d;
    end
  end

  // storage array, left unreset; popcounts are stored alongside the data words
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_d0[wptr_q] <= cap_d0_q;
      mem_d1[wptr_q] <= cap_d1_q;
      mem_p0[wptr_q] <= pc0;
      mem_p1[wptr_q] <= pc1;
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_data_0    = rdd0_q;
  assign rd_data_1    = rdd1_q;
  assign rd_popcnt_0  = rdp0_q;
  assign rd_popcnt_1  = rdp1_q;
  assign fifo_count   = cnt_q;
  assign fifo_empty   = empty_q;
  assign fifo_full    = full_q;
  assign overflow_cnt = ovf_q;
endmodule
